// File: rtl/alu_seq_if.sv
// Handshake bundle between operand fetch (master) and alu_seq (slave):
// valid/ready request with operands, valid/ready response with result and flags.
interface alu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] scrA;
  logic [XLEN-1:0] scrB;
  logic [3:0]      AluControl;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ALUresult;
  logic [3:0]      Flag;
  logic            illegal;

  modport master (
    output in_valid, scrA, scrB, AluControl, out_ready,
    input  in_ready, out_valid, ALUresult, Flag, illegal
  );

  modport slave (
    input  in_valid, scrA, scrB, AluControl, out_ready,
    output in_ready, out_valid, ALUresult, Flag, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register straight into the result, op 10
// runs a radix-2 shift-add multiply, one multiplier bit per cycle.
module alu_seq #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] MUL_CYCLES = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT_ONE    = (SHW+1)'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state;
  logic [SHW:0]    count;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] result_q;
  logic [3:0]      flag_q;
  logic            illegal_q;
  logic            valid_q;

  logic            ready;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] alu_res;
  logic            alu_carry;
  logic            alu_ovf;
  logic            alu_ill;
  logic [3:0]      alu_flag;
  logic [XLEN:0]   mul_sum;

  assign ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept = bus.in_valid && ready;
  assign shamt  = bus.scrB[SHW-1:0];

  always_comb begin
    sum       = {1'b0, bus.scrA} + {1'b0, bus.scrB};
    diff      = bus.scrA - bus.scrB;
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (bus.AluControl)
      OP_ADD: begin
        alu_res   = sum[XLEN-1:0];
        alu_carry = sum[XLEN];
        alu_ovf   = (bus.scrA[XLEN-1] == bus.scrB[XLEN-1]) && (sum[XLEN-1] != bus.scrA[XLEN-1]);
      end
      OP_SUB: begin
        alu_res   = diff;
        alu_carry = bus.scrA < bus.scrB;
        alu_ovf   = (bus.scrA[XLEN-1] != bus.scrB[XLEN-1]) && (diff[XLEN-1] != bus.scrA[XLEN-1]);
      end
      OP_AND:  alu_res = bus.scrA & bus.scrB;
      OP_SLL:  alu_res = bus.scrA << shamt;
      OP_OR:   alu_res = bus.scrA | bus.scrB;
      OP_XOR:  alu_res = bus.scrA ^ bus.scrB;
      OP_SRL:  alu_res = bus.scrA >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(bus.scrA) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.scrA) < $signed(bus.scrB))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.scrA < bus.scrB)};
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
    alu_flag = alu_ill ? 4'b0000 : {alu_ovf, alu_carry, alu_res[XLEN-1], (alu_res == '0)};
  end

  // hi:lo holds the running product; lo doubles as the multiplier shift register.
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      result_q  <= '0;
      flag_q    <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else if (accept) begin
      if (bus.AluControl == OP_MUL) begin
        mcand   <= bus.scrA;
        lo      <= bus.scrB;
        hi      <= '0;
        count   <= MUL_CYCLES;
        valid_q <= 1'b0;
        state   <= MUL;
      end else begin
        result_q  <= alu_res;
        flag_q    <= alu_flag;
        illegal_q <= alu_ill;
        valid_q   <= 1'b1;
        state     <= DONE;
      end
    end else begin
      case (state)
        MUL: begin
          if (count != '0) begin
            hi    <= mul_sum[XLEN:1];
            lo    <= {mul_sum[0], lo[XLEN-1:1]};
            count <= count - CNT_ONE;
          end else begin
            result_q  <= lo;
            flag_q    <= {1'b0, (hi != '0), lo[XLEN-1], (lo == '0)};
            illegal_q <= 1'b0;
            valid_q   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.ALUresult = result_q;
  assign bus.Flag      = flag_q;
  assign bus.illegal   = illegal_q;
endmodule
